// File: rtl/bnn_fc_classifier.sv
// Binary fully-connected classifier: XNOR-popcount accumulation of a chunked
// activation stream against per-class weights, then a serial argmax over class scores.
module bnn_fc_classifier #(
    parameter int FAN_IN  = 960,
    parameter int CHUNK   = 64,
    parameter int N_CLASS = 10,
    parameter int bW      = 8,
    localparam int NCHUNK = FAN_IN / CHUNK,
    localparam int CW     = $clog2(N_CLASS),
    localparam int KW     = $clog2(NCHUNK),
    localparam int ACC_W  = $clog2(FAN_IN + 1),
    localparam int SW     = ((ACC_W > bW) ? ACC_W : bW) + 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [CHUNK-1:0]     in_data,
    input  logic                 w_we,
    input  logic [CW-1:0]        w_class,
    input  logic [KW-1:0]        w_chunk,
    input  logic [CHUNK-1:0]     w_data,
    input  logic                 b_we,
    input  logic [CW-1:0]        b_class,
    input  logic signed [bW-1:0] b_data,
    output logic                 class_out_valid,
    input  logic                 class_out_ready,
    output logic [CW-1:0]        class_out,
    output logic signed [SW-1:0] score_out
);

    localparam logic [1:0] S_ACCUM = 2'd0;
    localparam logic [1:0] S_SCAN  = 2'd1;
    localparam logic [1:0] S_OUT   = 2'd2;

    logic [1:0]              state_q, state_d;
    logic [KW-1:0]           chunk_q, chunk_d;
    logic [ACC_W-1:0]        acc_q [N_CLASS];
    logic [ACC_W-1:0]        acc_d [N_CLASS];
    logic [CW:0]             scan_q, scan_d;
    logic signed [SW-1:0]    cand_score_q, cand_score_d;
    logic [CW-1:0]           cand_idx_q, cand_idx_d;
    logic signed [SW-1:0]    best_score_q, best_score_d;
    logic [CW-1:0]           best_idx_q, best_idx_d;
    logic [CW-1:0]           class_out_q, class_out_d;
    logic signed [SW-1:0]    score_out_q, score_out_d;

    logic [CHUNK-1:0]        w_mem_q [N_CLASS][NCHUNK];
    logic signed [bW-1:0]    b_mem_q [N_CLASS];
    logic [ACC_W-1:0]        match_cnt [N_CLASS];
    logic [CW-1:0]           scan_idx;

    assign scan_idx        = scan_q[CW-1:0];
    assign in_ready        = (state_q == S_ACCUM);
    assign class_out_valid = (state_q == S_OUT);
    assign class_out       = class_out_q;
    assign score_out       = score_out_q;

    // Per-class count of activations agreeing with the weight bit in the current chunk.
    always_comb begin
        logic [CHUNK-1:0] xnor_v;
        xnor_v = '0;
        for (int c = 0; c < N_CLASS; c++) begin
            xnor_v       = ~(in_data ^ w_mem_q[c][chunk_q]);
            match_cnt[c] = '0;
            for (int j = 0; j < CHUNK; j++) begin
                match_cnt[c] = match_cnt[c] + ACC_W'(xnor_v[j]);
            end
        end
    end

    // SCAN is a two-stage pipe: score of class scan_q is formed while the previous
    // class's score is compared, so one drain cycle follows the last class.
    always_comb begin
        state_d      = state_q;
        chunk_d      = chunk_q;
        acc_d        = acc_q;
        scan_d       = scan_q;
        cand_score_d = cand_score_q;
        cand_idx_d   = cand_idx_q;
        best_score_d = best_score_q;
        best_idx_d   = best_idx_q;
        class_out_d  = class_out_q;
        score_out_d  = score_out_q;
        case (state_q)
            S_ACCUM: begin
                if (in_valid) begin
                    for (int c = 0; c < N_CLASS; c++) begin
                        acc_d[c] = acc_q[c] + match_cnt[c];
                    end
                    if (chunk_q == KW'(NCHUNK - 1)) begin
                        chunk_d = '0;
                        scan_d  = '0;
                        state_d = S_SCAN;
                    end else begin
                        chunk_d = chunk_q + KW'(1);
                    end
                end
            end
            S_SCAN: begin
                if (int'(scan_q) < N_CLASS) begin
                    cand_score_d = signed'(SW'(acc_q[scan_idx])) + SW'(b_mem_q[scan_idx]);
                    cand_idx_d   = scan_idx;
                end
                if (scan_q != '0) begin
                    if (int'(scan_q) == 1 || cand_score_q > best_score_q) begin
                        best_score_d = cand_score_q;
                        best_idx_d   = cand_idx_q;
                    end
                end
                scan_d = scan_q + (CW+1)'(1);
                if (int'(scan_q) == N_CLASS) begin
                    class_out_d = best_idx_d;
                    score_out_d = best_score_d;
                    state_d     = S_OUT;
                end
            end
            S_OUT: begin
                if (class_out_ready) begin
                    for (int c = 0; c < N_CLASS; c++) begin
                        acc_d[c] = '0;
                    end
                    chunk_d = '0;
                    state_d = S_ACCUM;
                end
            end
            default: state_d = S_ACCUM;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours, regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_ACCUM;
            chunk_q      <= '0;
            scan_q       <= '0;
            cand_score_q <= '0;
            cand_idx_q   <= '0;
            best_score_q <= '0;
            best_idx_q   <= '0;
            class_out_q  <= '0;
            score_out_q  <= '0;
            for (int c = 0; c < N_CLASS; c++) begin
                acc_q[c] <= '0;
            end
        end else begin
            state_q      <= state_d;
            chunk_q      <= chunk_d;
            scan_q       <= scan_d;
            cand_score_q <= cand_score_d;
            cand_idx_q   <= cand_idx_d;
            best_score_q <= best_score_d;
            best_idx_q   <= best_idx_d;
            class_out_q  <= class_out_d;
            score_out_q  <= score_out_d;
            acc_q        <= acc_d;
        end
    end

    // NOTE: weight and bias storage has no reset branch on purpose: the trained
    // parameters must survive rst, and leaving memories unreset keeps them RAM-mappable.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (w_we && int'(w_class) < N_CLASS && int'(w_chunk) < NCHUNK) begin
                w_mem_q[w_class][w_chunk] <= w_data;
            end
            if (b_we && int'(b_class) < N_CLASS) begin
                b_mem_q[b_class] <= b_data;
            end
        end
    end

endmodule

// File: doc/bnn_fc_classifier.md
BNN_FC_CLASSIFIER -- requirements
Module: bnn_fc_classifier

Interface
REQ-001 SHALL have parameter FAN_IN, default 960: number of binary input activations per frame.
REQ-002 SHALL have parameter CHUNK, default 64: input bits accepted per handshake; FAN_IN SHALL be an integer multiple of CHUNK.
REQ-003 SHALL have parameter N_CLASS, default 10: number of output classes; N_CLASS >= 2.
REQ-004 SHALL have parameter bW, default 8: signed per-class bias width.
REQ-005 SHALL derive NCHUNK = FAN_IN/CHUNK, CW = clog2(N_CLASS), KW = clog2(NCHUNK), ACC_W = clog2(FAN_IN+1), SW = max(ACC_W,bW)+2.
REQ-006 SHALL have the port clk, input, 1 bit: the single clock; every register updates on its rising edge.
REQ-007 SHALL have the port rst, input, 1 bit: reset, synchronous and active-high.
REQ-008 SHALL have the ports in_valid (input, 1), in_ready (output, 1) and in_data (input, CHUNK bits): the activation chunk stream; bit j of chunk k is activation k*CHUNK+j.
REQ-009 SHALL have the ports w_we (input, 1), w_class (input, CW), w_chunk (input, KW) and w_data (input, CHUNK): the binary weight write port.
REQ-010 SHALL have the ports b_we (input, 1), b_class (input, CW) and b_data (input, bW signed): the bias write port.
REQ-011 SHALL have the ports class_out_valid (output, 1), class_out_ready (input, 1), class_out (output, CW) and score_out (output, SW signed): the result.

Function
REQ-012 SHALL implement an FSM with states ACCUM, SCAN and OUT.
REQ-013 In ACCUM, in_ready SHALL be 1; in SCAN and OUT, in_ready SHALL be 0.
REQ-014 A chunk SHALL be accepted on a clk edge where in_valid and in_ready are both 1; otherwise accumulator and chunk state hold.
REQ-015 On each accepted chunk at chunk counter k, every class c SHALL add popcount(~(in_data ^ W[c][k])) to acc[c] in the same cycle.
REQ-016 The chunk counter SHALL wrap to 0 after NCHUNK-1.
REQ-017 Accepting chunk NCHUNK-1 SHALL move the FSM to SCAN.
REQ-018 SCAN SHALL evaluate one class per cycle, index 0..N_CLASS-1, with score[c] = acc[c] + sign-extended bias[c] at width SW, with no overflow.
REQ-019 SCAN SHALL keep the running maximum using a strict greater-than, so ties resolve to the lowest index.
REQ-020 After N_CLASS SCAN cycles, the FSM SHALL move to OUT.
REQ-021 class_out_valid SHALL assert exactly N_CLASS+1 cycles after the edge that accepts the last chunk.
REQ-022 In OUT, class_out_valid SHALL be 1 and class_out/score_out SHALL hold the winning index and score, stable while class_out_ready is 0.
REQ-023 An OUT edge with class_out_ready=1 SHALL move the FSM to ACCUM and clear all acc[c] and the chunk counter.
REQ-024 The earliest next-frame chunk SHALL be accepted on the following edge; class_out_valid SHALL return to 0.
REQ-025 Outside OUT, class_out_valid SHALL be 0; class_out and score_out SHALL retain their last values.
REQ-026 Weight and bias writes SHALL be accepted in any state and become visible on the next cycle.
REQ-027 A same-cycle read of a location being written SHALL use the old value.
REQ-028 Simultaneous w_we and b_we SHALL both take effect.
REQ-029 in_valid while in_ready=0 SHALL be ignored and SHALL NOT advance the counter.

Reset
REQ-030 rst=1 at a clk edge SHALL force FSM=ACCUM, chunk counter=0, all acc=0, class_out_valid=0, class_out=0, score_out=0, in_ready=1 on the following cycle, including mid-frame, mid-SCAN or in OUT.
REQ-031 Reset SHALL NOT clear the weight or bias storage; the contents persist across rst.
REQ-032 While rst=1, input handshakes and weight/bias writes SHALL be ignored.

Verification
REQ-033 Config FAN_IN=16, CHUNK=8, N_CLASS=4: W[2]=all ones, others all zeros, biases 0, input all ones (2 chunks back-to-back) -> class_out=2, score_out=16, valid 5 cycles after the 2nd accept.
REQ-034 Same config, all W=0, biases {3,-2,3,1}, input all zeros -> class_out=0 (tie with class 2), score_out=19.
REQ-035 Backpressure: hold class_out_ready=0 for 7 cycles in OUT -> valid and outputs stable, in_ready=0 and in_valid ignored; release -> next frame accepted on the following edge with acc cleared.
REQ-036 Assert rst after the 1st of 2 chunks -> in_ready=1, counter=0; a fresh full frame then gives the same result as REQ-033.
REQ-037 Default params, random weights, biases and input across 50 frames with random in_valid gaps -> class_out/score_out match the reference model; weight rewrite between frames is reflected in the next frame.
